// File: rtl/sphincs_hmac_prf_gen.sv
// SPHINCS+ PRF_msg generator: R = HMAC-SHA256(sk_prf, optrand||msg) truncated to N bytes.
// One iterative SHA-256 compression core is shared by all key, data and outer blocks.

module RTL_crypto_hashblocks_sha256 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_in,
  input  logic [255:0] state_in,
  input  logic [511:0] block_in,
  output logic         valid_out,
  output logic [255:0] digest_out
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] iv_q [8];
  logic [31:0] v_q  [8];
  logic [31:0] w_q  [16];
  logic [31:0] v_d  [8];
  logic [31:0] w_d;
  logic [31:0] t1, t2;
  logic [5:0]  rnd_q;
  logic        run_q;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 round plus the next message-schedule word
  always_comb begin
    t1 = v_q[7]
       + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
       + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
       + K[rnd_q] + w_q[0];
    t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
       + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    w_d = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
        + w_q[9]
        + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
        + w_q[0];
    v_d[0] = t1 + t2;
    v_d[1] = v_q[0];
    v_d[2] = v_q[1];
    v_d[3] = v_q[2];
    v_d[4] = v_q[3] + t1;
    v_d[5] = v_q[4];
    v_d[6] = v_q[5];
    v_d[7] = v_q[6];
  end

  // Latch state/block on start, run 64 rounds, then add the chaining value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        iv_q[i] <= '0;
        v_q[i]  <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      rnd_q      <= '0;
      run_q      <= 1'b0;
      valid_out  <= 1'b0;
      digest_out <= '0;
    end else begin
      valid_out <= 1'b0;
      if (run_q) begin
        for (int i = 0; i < 8; i++) v_q[i] <= v_d[i];
        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
        w_q[15] <= w_d;
        rnd_q   <= rnd_q + 6'd1;
        if (rnd_q == 6'd63) begin
          run_q     <= 1'b0;
          valid_out <= 1'b1;
          for (int i = 0; i < 8; i++)
            digest_out[255-32*i -: 32] <= iv_q[i] + v_d[i];
        end
      end else if (start_in) begin
        for (int i = 0; i < 8; i++) begin
          iv_q[i] <= state_in[255-32*i -: 32];
          v_q[i]  <= state_in[255-32*i -: 32];
        end
        for (int i = 0; i < 16; i++)
          w_q[i] <= block_in[511-32*i -: 32];
        rnd_q <= '0;
        run_q <= 1'b1;
      end
    end
  end
endmodule

module sphincs_hmac_prf_gen #(
  parameter int N         = 16,
  parameter int MSG_BYTES = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*N-1:0]         sk_prf,
  input  logic [8*N-1:0]         optrand,
  input  logic [8*MSG_BYTES-1:0] msg,
  output logic                   busy,
  output logic [8*N-1:0]         R,
  output logic                   valid
);
  localparam int D    = N + MSG_BYTES;
  localparam int NBI  = (D + 9 + 63) / 64;
  localparam int PADW = 2048 - 8*D - 8;
  localparam logic [1:0]    LAST = 2'(NBI - 1);
  localparam logic [63:0]   LEN  = 64'((64 + D) * 8);
  localparam logic [2047:0] LENV = {1984'd0, LEN} << (2048 - 512*NBI);
  localparam logic [255:0]  IV   = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  if (!(N == 16 || N == 24 || N == 32)) begin : g_bad_n
    $error("sphincs_hmac_prf_gen: N must be 16, 24 or 32");
  end
  if (MSG_BYTES < 1 || MSG_BYTES > 247 - N) begin : g_bad_msg
    $error("sphincs_hmac_prf_gen: MSG_BYTES out of range 1..247-N");
  end

  typedef enum logic [2:0] {IDLE, IKEY, IDAT, OKEY, ODAT, DRAIN} state_t;

  state_t                 state_q;
  logic [8*N-1:0]         sk_q, opt_q, r_q;
  logic [8*MSG_BYTES-1:0] msg_q;
  logic [255:0]           cv_q, idig_q;
  logic [1:0]             cnt_q;
  logic                   cs_q, busy_q, valid_q;

  logic [511:0]  kp, blk_d;
  logic [2047:0] tail;
  logic [255:0]  dig;
  logic          core_vld, core_rst_n;

  assign core_rst_n = ~RST;
  assign kp   = {sk_q, {(64-N)*8{1'b0}}};
  assign tail = {opt_q, msg_q, 8'h80, {PADW{1'b0}}} | LENV;

  assign busy  = busy_q;
  assign valid = valid_q;
  assign R     = r_q;

  // Block fed to the core for the block issued in the current state
  always_comb begin
    blk_d = '0;
    case (state_q)
      IKEY: blk_d = kp ^ {64{8'h36}};
      IDAT: begin
        case (cnt_q)
          2'd0:    blk_d = tail[2047:1536];
          2'd1:    blk_d = tail[1535:1024];
          2'd2:    blk_d = tail[1023:512];
          default: blk_d = tail[511:0];
        endcase
      end
      OKEY: blk_d = kp ^ {64{8'h5c}};
      ODAT: blk_d = {idig_q, 8'h80, 184'd0, 64'h300};
      default: blk_d = '0;
    endcase
  end

  RTL_crypto_hashblocks_sha256 u_core (
    .clk        (CLK),
    .rst_n      (core_rst_n),
    .start_in   (cs_q),
    .state_in   (cv_q),
    .block_in   (blk_d),
    .valid_out  (core_vld),
    .digest_out (dig)
  );

  // Sequencer: key block, tail blocks, outer key, outer tail; abort drains
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sk_q    <= '0;
      opt_q   <= '0;
      msg_q   <= '0;
      cv_q    <= '0;
      idig_q  <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      r_q     <= '0;
    end else begin
      cs_q    <= 1'b0;
      valid_q <= 1'b0;
      if (state_q != IDLE && abort) begin
        if (core_vld) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          state_q <= DRAIN;
        end
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
            if (start && !busy_q) begin
              sk_q    <= sk_prf;
              opt_q   <= optrand;
              msg_q   <= msg;
              cv_q    <= IV;
              cs_q    <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= IKEY;
            end
          end
          IKEY: if (core_vld) begin
            cv_q    <= dig;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            state_q <= IDAT;
          end
          IDAT: if (core_vld) begin
            cv_q <= dig;
            cs_q <= 1'b1;
            if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
            if (cnt_q == LAST) begin
              idig_q  <= dig;
              cv_q    <= IV;
              state_q <= OKEY;
            end
          end
          OKEY: if (core_vld) begin
            cv_q    <= dig;
            cs_q    <= 1'b1;
            state_q <= ODAT;
          end
          ODAT: if (core_vld) begin
            r_q     <= dig[255 -: 8*N];
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
          DRAIN: if (core_vld) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sphincs_hmac_prf_gen.sv
// Directed bench for sphincs_hmac_prf_gen with a behavioural HMAC-SHA256 model.
// Three instances cover 1, 2 and 4 inner tail blocks.

module tb_sphincs_hmac_prf_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start1, abort1, busy1, valid1;
  logic [127:0] sk1, opt1, R1;
  logic [255:0] msg1;
  logic         start2, abort2, busy2, valid2;
  logic [127:0] sk2, opt2, R2;
  logic [447:0] msg2;
  logic          start3, abort3, busy3, valid3;
  logic [255:0]  sk3, opt3, R3;
  logic [1719:0] msg3;

  int nvec = 0;
  int nerr = 0;
  int starts1 = 0, starts2 = 0, starts3 = 0, nval1 = 0;
  logic [511:0] blks1[$];

  sphincs_hmac_prf_gen #(.N(16), .MSG_BYTES(32)) u1 (
    .CLK(clk), .RST(rst), .start(start1), .abort(abort1),
    .sk_prf(sk1), .optrand(opt1), .msg(msg1),
    .busy(busy1), .R(R1), .valid(valid1));
  sphincs_hmac_prf_gen #(.N(16), .MSG_BYTES(56)) u2 (
    .CLK(clk), .RST(rst), .start(start2), .abort(abort2),
    .sk_prf(sk2), .optrand(opt2), .msg(msg2),
    .busy(busy2), .R(R2), .valid(valid2));
  sphincs_hmac_prf_gen #(.N(32), .MSG_BYTES(215)) u3 (
    .CLK(clk), .RST(rst), .start(start3), .abort(abort3),
    .sk_prf(sk3), .optrand(opt3), .msg(msg3),
    .busy(busy3), .R(R3), .valid(valid3));

  always @(posedge clk) begin
    if (u1.u_core.start_in) begin
      starts1++;
      blks1.push_back(u1.u_core.block_in);
    end
    if (u2.u_core.start_in) starts2++;
    if (u3.u_core.start_in) starts3++;
    if (valid1) nval1++;
  end

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return 32'({x, x} >> n);
  endfunction

  function automatic logic [255:0] sha256(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [31:0] H[8];
    logic [31:0] W[64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [63:0] bl;
    p = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    H = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int bk = 0; bk < p.size() / 64; bk++) begin
      for (int t = 0; t < 16; t++)
        W[t] = {p[64*bk+4*t], p[64*bk+4*t+1], p[64*bk+4*t+2], p[64*bk+4*t+3]};
      for (int t = 16; t < 64; t++)
        W[t] = (ror(W[t-2], 17) ^ ror(W[t-2], 19) ^ (W[t-2] >> 10)) + W[t-7]
             + (ror(W[t-15], 7) ^ ror(W[t-15], 18) ^ (W[t-15] >> 3)) + W[t-16];
      a = H[0]; b = H[1]; c = H[2]; d = H[3];
      e = H[4]; f = H[5]; g = H[6]; h = H[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + W[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1;
        d = c; c = b; b = a; a = t1 + t2;
      end
      H[0] += a; H[1] += b; H[2] += c; H[3] += d;
      H[4] += e; H[5] += f; H[6] += g; H[7] += h;
    end
    return {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]};
  endfunction

  function automatic logic [255:0] hmac(input logic [2047:0] key, input int kl,
                                        input logic [2047:0] dat, input int dl);
    logic [7:0]   ip[$];
    logic [7:0]   op[$];
    logic [7:0]   kb;
    logic [255:0] hi;
    for (int i = 0; i < 64; i++) begin
      kb = (i < kl) ? key[8*(kl-1-i) +: 8] : 8'h00;
      ip.push_back(kb ^ 8'h36);
      op.push_back(kb ^ 8'h5c);
    end
    for (int i = 0; i < dl; i++) ip.push_back(dat[8*(dl-1-i) +: 8]);
    hi = sha256(ip);
    for (int i = 0; i < 32; i++) op.push_back(hi[8*(31-i) +: 8]);
    return sha256(op);
  endfunction

  function automatic logic [127:0] exp1(input logic [127:0] k, input logic [127:0] o,
                                        input logic [255:0] m);
    logic [255:0] hh;
    hh = hmac(2048'(k), 16, 2048'({o, m}), 48);
    return hh[255:128];
  endfunction

  function automatic logic [127:0] pat16(input int s);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*(15-i) +: 8] = 8'(i * 13 + s);
    return v;
  endfunction

  task automatic wait_valid1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (valid1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {start1, abort1, start2, abort2, start3, abort3} = '0;
    sk1 = '0; opt1 = '0; msg1 = '0;
    sk2 = '0; opt2 = '0; msg2 = '0;
    sk3 = '0; opt3 = '0; msg3 = '0;
    repeat (3) @(negedge clk);
    nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy1); end
    nvec++; if (valid1 !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", valid1); end
    nvec++; if (R1 !== '0) begin nerr++; $display("FAIL reset_R got %h want 0", R1); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_model();
    logic [7:0]   q[$];
    logic [255:0] h;
    logic [223:0] s;
    q.push_back(8'h61); q.push_back(8'h62); q.push_back(8'h63);
    h = sha256(q);
    nvec++;
    if (h !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      nerr++; $display("FAIL model_sha_abc got %h", h);
    end
    s = "what do ya want for nothing?";
    h = hmac(2048'(32'h4a656665), 4, 2048'(s), 28);
    nvec++;
    if (h !== 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843) begin
      nerr++; $display("FAIL model_hmac_rfc4231 got %h", h);
    end
  endtask

  task automatic test_single();
    int base, nv;
    bit ok;
    logic [127:0] e;
    for (int i = 0; i < 16; i++) sk1[8*(15-i) +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) opt1[8*(15-i) +: 8] = 8'(16 + i);
    for (int i = 0; i < 32; i++) msg1[8*(31-i) +: 8] = 8'(32 + i);
    e = exp1(sk1, opt1, msg1);
    base = starts1; nv = nval1;
    blks1.delete();
    pulse_start1();
    wait_valid1(ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL single_timeout got no valid want valid"); end
    nvec++; if (R1 !== e) begin nerr++; $display("FAIL single_R got %h want %h", R1, e); end
    nvec++; if (busy1 !== 1'b1) begin nerr++; $display("FAIL single_busy_at_valid got %b want 1", busy1); end
    repeat (5) @(negedge clk);
    nvec++; if (starts1 - base !== 4) begin nerr++; $display("FAIL single_core_starts got %0d want 4", starts1 - base); end
    nvec++; if (nval1 - nv !== 1) begin nerr++; $display("FAIL single_valid_count got %0d want 1", nval1 - nv); end
    nvec++;
    if (blks1.size() < 4) begin
      nerr++; $display("FAIL single_blocks got %0d blocks want 4", blks1.size());
    end else begin
      if (blks1[0] !== ({sk1, 384'd0} ^ {64{8'h36}})) begin
        nerr++; $display("FAIL single_ikey_block got %h", blks1[0]);
      end
      nvec++;
      if (blks1[1][63:0] !== 64'h380) begin
        nerr++; $display("FAIL single_len_field got %h want 380", blks1[1][63:0]);
      end
      nvec++;
      if (blks1[1][511:120] !== {opt1, msg1, 8'h80}) begin
        nerr++; $display("FAIL single_tail_block got %h", blks1[1][511:120]);
      end
    end
  endtask

  task automatic test_multi_block();
    int base, lowb;
    bit ok;
    logic [255:0] hh;
    logic [127:0] e2;
    logic [255:0] e3;
    for (int i = 0; i < 16; i++) sk2[8*(15-i) +: 8] = 8'(i * 7 + 3);
    for (int i = 0; i < 16; i++) opt2[8*(15-i) +: 8] = 8'(i * 5 + 1);
    for (int i = 0; i < 56; i++) msg2[8*(55-i) +: 8] = 8'(i * 11 + 9);
    hh = hmac(2048'(sk2), 16, 2048'({opt2, msg2}), 72);
    e2 = hh[255:128];
    base = starts2;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    lowb = 0; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (valid2) begin ok = 1'b1; break; end
      if (!busy2) lowb++;
      @(negedge clk);
    end
    nvec++; if (!ok) begin nerr++; $display("FAIL nbi2_timeout got no valid want valid"); end
    nvec++; if (R2 !== e2) begin nerr++; $display("FAIL nbi2_R got %h want %h", R2, e2); end
    nvec++; if (lowb !== 0) begin nerr++; $display("FAIL nbi2_busy got %0d low cycles want 0", lowb); end
    nvec++; if (starts2 - base !== 5) begin nerr++; $display("FAIL nbi2_starts got %0d want 5", starts2 - base); end

    for (int i = 0; i < 32; i++) sk3[8*(31-i) +: 8] = 8'(255 - i * 3);
    for (int i = 0; i < 32; i++) opt3[8*(31-i) +: 8] = 8'(i * 9 + 4);
    for (int i = 0; i < 215; i++) msg3[8*(214-i) +: 8] = 8'(i * 17 + 2);
    e3 = hmac(2048'(sk3), 32, 2048'({opt3, msg3}), 247);
    base = starts3;
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    lowb = 0; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (valid3) begin ok = 1'b1; break; end
      if (!busy3) lowb++;
      @(negedge clk);
    end
    nvec++; if (!ok) begin nerr++; $display("FAIL nbi4_timeout got no valid want valid"); end
    nvec++; if (R3 !== e3) begin nerr++; $display("FAIL nbi4_R got %h want %h", R3, e3); end
    nvec++; if (lowb !== 0) begin nerr++; $display("FAIL nbi4_busy got %0d low cycles want 0", lowb); end
    nvec++; if (starts3 - base !== 7) begin nerr++; $display("FAIL nbi4_starts got %0d want 7", starts3 - base); end
  endtask

  task automatic test_start_hold();
    int base, nv;
    bit ok;
    logic [127:0] e;
    sk1 = pat16(41); opt1 = pat16(90);
    for (int i = 0; i < 32; i++) msg1[8*(31-i) +: 8] = 8'(200 - i);
    e = exp1(sk1, opt1, msg1);
    base = starts1; nv = nval1;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 msg1 = ~msg1;
    @(posedge clk);
    @(posedge clk); #1 start1 = 1'b0;
    wait_valid1(ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL hold_timeout got no valid want valid"); end
    nvec++; if (R1 !== e) begin nerr++; $display("FAIL hold_R got %h want %h", R1, e); end
    repeat (100) @(negedge clk);
    nvec++; if (nval1 - nv !== 1) begin nerr++; $display("FAIL hold_valid_count got %0d want 1", nval1 - nv); end
    nvec++; if (starts1 - base !== 4) begin nerr++; $display("FAIL hold_starts got %0d want 4", starts1 - base); end
    nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL hold_busy_after got %b want 0", busy1); end
  endtask

  task automatic test_abort();
    int base, nv;
    bit ok;
    logic [127:0] prev, e;
    sk1 = pat16(77); opt1 = pat16(5);
    for (int i = 0; i < 32; i++) msg1[8*(31-i) +: 8] = 8'(i * 3);
    e = exp1(sk1, opt1, msg1);
    prev = R1; base = starts1; nv = nval1;
    pulse_start1();
    for (int i = 0; i < 500; i++) begin
      if (starts1 - base >= 2) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    abort1 = 1'b1;
    @(negedge clk) abort1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (u1.u_core.valid_out) begin ok = 1'b1; break; end
    end
    nvec++; if (!ok) begin nerr++; $display("FAIL abort_drain_timeout got no core valid want one"); end
    nvec++; if (busy1 !== 1'b1) begin nerr++; $display("FAIL abort_busy_drain got %b want 1", busy1); end
    @(negedge clk);
    nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL abort_busy_after got %b want 0", busy1); end
    repeat (80) @(negedge clk);
    nvec++; if (nval1 !== nv) begin nerr++; $display("FAIL abort_valid got %0d pulses want 0", nval1 - nv); end
    nvec++; if (R1 !== prev) begin nerr++; $display("FAIL abort_R_kept got %h want %h", R1, prev); end
    nvec++; if (starts1 - base !== 2) begin nerr++; $display("FAIL abort_starts got %0d want 2", starts1 - base); end
    pulse_start1();
    wait_valid1(ok);
    nvec++; if (!ok || R1 !== e) begin nerr++; $display("FAIL abort_next_R got %h want %h", R1, e); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base, nv;
    bit ok;
    logic [127:0] e;
    sk1 = pat16(123); opt1 = pat16(66);
    e = exp1(sk1, opt1, msg1);
    base = starts1;
    pulse_start1();
    for (int i = 0; i < 1000; i++) begin
      if (starts1 - base >= 3) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL rstmid_busy got %b want 0", busy1); end
    nvec++; if (valid1 !== 1'b0) begin nerr++; $display("FAIL rstmid_valid got %b want 0", valid1); end
    nvec++; if (R1 !== '0) begin nerr++; $display("FAIL rstmid_R got %h want 0", R1); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nv = nval1;
    repeat (400) @(negedge clk);
    nvec++; if (nval1 !== nv) begin nerr++; $display("FAIL rstmid_late_valid got %0d want 0", nval1 - nv); end
    base = starts1;
    pulse_start1();
    wait_valid1(ok);
    nvec++; if (!ok || R1 !== e) begin nerr++; $display("FAIL rstmid_next_R got %h want %h", R1, e); end
    repeat (3) @(negedge clk);
    nvec++; if (starts1 - base !== 4) begin nerr++; $display("FAIL rstmid_starts got %0d want 4", starts1 - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    logic [127:0] ea, eb;
    sk1 = pat16(200); opt1 = pat16(17);
    ea = exp1(sk1, opt1, msg1);
    base = starts1;
    pulse_start1();
    wait_valid1(ok);
    nvec++; if (!ok || R1 !== ea) begin nerr++; $display("FAIL b2b_first_R got %h want %h", R1, ea); end
    sk1 = pat16(31);
    eb = exp1(sk1, opt1, msg1);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_valid1(ok);
    nvec++; if (!ok || R1 !== eb) begin nerr++; $display("FAIL b2b_second_R got %h want %h", R1, eb); end
    repeat (3) @(negedge clk);
    nvec++; if (starts1 - base !== 8) begin nerr++; $display("FAIL b2b_starts got %0d want 8", starts1 - base); end
  endtask

  task automatic test_start_on_valid();
    int b;
    bit ok;
    pulse_start1();
    wait_valid1(ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL onvalid_timeout got no valid want valid"); end
    b = starts1;
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL onvalid_busy got %b want 0", busy1); end
    nvec++; if (starts1 !== b) begin nerr++; $display("FAIL onvalid_starts got %0d want 0 new", starts1 - b); end
  endtask

  initial begin
    test_reset();
    test_model();
    test_single();
    test_multi_block();
    test_start_hold();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_start_on_valid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sphincs_hmac_prf_gen.md
SPHINCS_HMAC_PRF_GEN -- requirements
Module: sphincs_hmac_prf_gen

Interface
REQ-001 Parameter N, default 16: secret-key, optrand and output length in bytes; legal values 16, 24, 32.
REQ-002 Parameter MSG_BYTES, default 32: message length in bytes; legal range 1..(247-N); an illegal value SHALL stop elaboration.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request; accepted only while busy=0.
REQ-006 abort  input  1  cancel the current operation; ignored while busy=0.
REQ-007 sk_prf  input  8*N  HMAC key, big-endian byte order (MSB is byte 0).
REQ-008 optrand  input  8*N  randomness prefix, big-endian.
REQ-009 msg  input  8*MSG_BYTES  message, big-endian.
REQ-010 busy  output  1  high from the cycle after an accepted start until the cycle valid pulses or the abort drain ends.
REQ-011 R  output  8*N  first N bytes of HMAC-SHA256(sk_prf, optrand||msg).
REQ-012 valid  output  1  one-cycle pulse; R is valid in the same cycle and holds until the next valid.

Function
REQ-013 One RTL_crypto_hashblocks_sha256 instance is used for all compression calls.
- Its active-low reset input SHALL be driven by the inverse of RST.
- Exactly one core start is outstanding at any time.
REQ-014 On an accepted start, sk_prf, optrand and msg SHALL be registered; later input changes SHALL NOT affect the result.
REQ-015 K' = sk_prf followed by (64-N) zero bytes.
- Inner key block = K' XOR 0x36 repeated.
- Outer key block = K' XOR 0x5c repeated.
REQ-016 D = N + MSG_BYTES.
- Inner tail stream = optrand||msg||0x80||zero bytes||64-bit big-endian length (64+D)*8.
- The tail is NBI = ceil((D+9)/64) blocks, with NBI in 1..4.
REQ-017 Outer tail block = inner digest (32 bytes)||0x80||23 zero bytes||64-bit length 0x300.
REQ-018 The chaining value SHALL be held in a register.
- SHA-256 IV SHALL be loaded for each key block.
- The latched core digest_out SHALL be used for every following block.
- Combinational feedback of digest_out SHALL NOT be used.
REQ-019 FSM states: IDLE, IKEY, IDAT, OKEY, ODAT, DRAIN.
- Each non-IDLE state issues a one-cycle core start on entry, then waits for core valid_out.
REQ-020 Transitions:
- IDLE -start-> IKEY -valid_out-> IDAT.
- IDAT loops on valid_out until block counter = NBI-1, then -valid_out-> OKEY.
- OKEY -valid_out-> ODAT.
- ODAT -valid_out-> IDLE, with valid=1 and R = digest_out[255:256-8N].
REQ-021 Block counter: 2 bits, cleared on entry to IDAT, incremented on each IDAT valid_out; it SHALL NOT wrap.
REQ-022 Inner digest is latched on the final IDAT valid_out.
REQ-023 Abort in any non-IDLE state:
- Go to DRAIN; wait for the outstanding core valid_out, then go to IDLE.
- No valid pulse is produced; R is unchanged; busy stays 1 during DRAIN.
- Abort in the same cycle as a valid_out that would end ODAT takes priority: go to IDLE directly, no valid pulse.
REQ-024 Start while busy=1 SHALL be ignored; it is not queued.
- Start in the cycle valid pulses SHALL be ignored, because busy was still 1 in that cycle.
REQ-025 Total core starts per operation = NBI+3.

Reset
REQ-026 While RST=1, asynchronously:
- state=IDLE, busy=0, valid=0, R=0, chaining/inner-digest registers=0, block counter=0.
- Core held in reset.
REQ-027 Reset mid-operation discards all progress; no valid pulse follows its release.
REQ-028 The first start accepted after RST falls SHALL behave exactly as one accepted from power-up.

Verification
REQ-029 N=16, MSG_BYTES=32, sk_prf=0x000102..0f, optrand=0x10..1f, msg=0x20..3f, one start -> exactly 4 core starts; inner tail length field 0x380; one valid; R = first 16 bytes of the bench HMAC-SHA256 model.
REQ-030 N=16, MSG_BYTES=56 (NBI=2) and N=32, MSG_BYTES=215 (NBI=4) -> 5 and 7 core starts respectively; R matches the model; busy high throughout each operation.
REQ-031 Start held high for 3 cycles, and msg changed one cycle after acceptance -> one operation only; R matches the originally latched msg.
REQ-032 Abort asserted during IDAT -> no valid pulse; busy falls one cycle after the outstanding core valid_out; a following start produces a correct R.
REQ-033 RST pulsed during OKEY -> busy=0, valid=0, R=0 immediately; no later valid; next start gives a correct R.
REQ-034 Two back-to-back operations with different keys, second start issued the cycle after valid -> both R values match the model; no stale chaining value carried over.
